alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit.sv | 166 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU behind a valid/ready handshake. Single-cycle logic and
// arithmetic ops; shifts iterate one bit per cycle through a one-bit shifter.
module alu_exec_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            ALUControl,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Zero,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_SRL = 3'b111;

   state_t                  state_reg, state_next;
   logic [DATA_WIDTH-1:0]   work_reg, work_next;
   logic [SHAMT_W-1:0]      count_reg, count_next;
   logic                    dir_reg, dir_next;
   logic [DATA_WIDTH-1:0]   result_reg, result_next;
   logic                    zero_reg, zero_next;

   logic [DATA_WIDTH-1:0]   b_operand;
   logic [DATA_WIDTH-1:0]   addsub;
   logic                    sub_sel;
   logic                    slt_bit;
   logic [DATA_WIDTH-1:0]   alu_res;
   logic [SHAMT_W-1:0]      shamt;
   logic                    is_shift;
   logic [DATA_WIDTH-1:0]   shl_one;
   logic [DATA_WIDTH-1:0]   shr_one;
   logic [DATA_WIDTH-1:0]   shift_one;

   // One adder serves add, sub and the signed compare for slt.
   assign sub_sel   = (ALUControl != OP_ADD);
   assign b_operand = sub_sel ? ~SrcB : SrcB;
   assign addsub    = SrcA + b_operand + {{(DATA_WIDTH-1){1'b0}}, sub_sel};
   assign slt_bit   = (SrcA[DATA_WIDTH-1] ^ SrcB[DATA_WIDTH-1]) ?
                      SrcA[DATA_WIDTH-1] : addsub[DATA_WIDTH-1];

   assign shamt    = SrcB[SHAMT_W-1:0];
   assign is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRL);

   always_comb begin
      alu_res = '0;
      unique case (ALUControl)
         OP_ADD:  alu_res = addsub;
         OP_SUB:  alu_res = addsub;
         OP_AND:  alu_res = SrcA & SrcB;
         OP_OR:   alu_res = SrcA | SrcB;
         OP_XOR:  alu_res = SrcA ^ SrcB;
         OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
         // Only reached with a zero shift amount: result is SrcA unchanged.
         OP_SLL:  alu_res = SrcA;
         OP_SRL:  alu_res = SrcA;
         default: alu_res = '0;
      endcase
   end

   // Single-bit shifter slice applied to the work register once per cycle.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
         if (gi == 0) begin : g_lsb
            assign shl_one[gi] = 1'b0;
         end else begin : g_lmid
            assign shl_one[gi] = work_reg[gi-1];
         end
         if (gi == DATA_WIDTH-1) begin : g_msb
            assign shr_one[gi] = 1'b0;
         end else begin : g_rmid
            assign shr_one[gi] = work_reg[gi+1];
         end
      end
   endgenerate

   assign shift_one = dir_reg ? shr_one : shl_one;

   always_comb begin
      state_next  = state_reg;
      work_next   = work_reg;
      count_next  = count_reg;
      dir_next    = dir_reg;
      result_next = result_reg;
      zero_next   = zero_reg;
      unique case (state_reg)
         IDLE: begin
            if (in_valid) begin
               if (is_shift && (shamt != '0)) begin
                  work_next  = SrcA;
                  count_next = shamt;
                  dir_next   = (ALUControl == OP_SRL);
                  state_next = SHIFT;
               end else begin
                  result_next = alu_res;
                  zero_next   = (alu_res == '0);
                  state_next  = DONE;
               end
            end
         end
         SHIFT: begin
            work_next  = shift_one;
            count_next = count_reg - SHAMT_W'(1);
            // Final step: the result registers take the last shifted value.
            if (count_reg == SHAMT_W'(1)) begin
               result_next = shift_one;
               zero_next   = (shift_one == '0);
               state_next  = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         work_reg   <= '0;
         count_reg  <= '0;
         dir_reg    <= 1'b0;
         result_reg <= '0;
         zero_reg   <= 1'b1;
      end else begin
         state_reg  <= state_next;
         work_reg   <= work_next;
         count_reg  <= count_next;
         dir_reg    <= dir_next;
         result_reg <= result_next;
         zero_reg   <= zero_next;
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign ALUResult = result_reg;
   assign Zero      = zero_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus a random
// handshake stream scored against a plain-arithmetic reference model.
module tb_alu_exec_unit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  ALUControl;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        busy;

   int n_checks;
   int n_fail;

   alu_exec_unit #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ALUControl (ALUControl),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ALUResult  (ALUResult),
      .Zero       (Zero),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd6:    return a << sh;
         default: return a >> sh;
      endcase
   endfunction

   // Drive one request from IDLE, scramble inputs after accept, measure latency.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat,
                        output bit busy_ok);
      @(negedge clk);
      ALUControl = op;
      SrcA       = a;
      SrcB       = b;
      in_valid   = 1'b1;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      SrcA       = $urandom;
      SrcB       = $urandom;
      ALUControl = 3'($urandom_range(0, 7));
      lat        = 1;
      busy_ok    = 1'b1;
      while (out_valid !== 1'b1 && lat < 100) begin
         if (in_ready !== 1'b0 || busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      if (in_ready !== 1'b0 || busy !== 1'b1) busy_ok = 1'b0;
      res = ALUResult;
      z   = Zero;
      $display("op=%0d a=%h b=%h res=%h zero=%b lat=%0d", op, a, b, res, z, lat);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || ALUResult !== 32'h0 ||
          Zero !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got in_ready=%b out_valid=%b res=%h zero=%b busy=%b, want 1 0 00000000 1 0",
                  in_ready, out_valid, ALUResult, Zero, busy);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_arith();
      logic [31:0] r; logic z; int l; bit bo;
      do_op(3'd0, 32'hFFFF_FFFF, 32'h1, r, z, l, bo);
      n_checks++;
      if (r !== 32'h0 || z !== 1'b1 || l != 1) begin
         n_fail++;
         $display("FAIL add_wrap: got res=%h zero=%b lat=%0d, want 00000000 1 1", r, z, l);
      end
      do_op(3'd1, 32'd5, 32'd7, r, z, l, bo);
      n_checks++;
      if (r !== 32'hFFFF_FFFE || z !== 1'b0 || l != 1) begin
         n_fail++;
         $display("FAIL sub_neg: got res=%h zero=%b lat=%0d, want fffffffe 0 1", r, z, l);
      end
   endtask

   task automatic test_slt_xor();
      logic [31:0] r; logic z; int l; bit bo;
      do_op(3'd5, 32'hFFFF_FFFF, 32'h1, r, z, l, bo);
      n_checks++;
      if (r !== 32'h1 || z !== 1'b0 || l != 1) begin
         n_fail++;
         $display("FAIL slt_neg_lt: got res=%h zero=%b lat=%0d, want 00000001 0 1", r, z, l);
      end
      do_op(3'd5, 32'h1, 32'hFFFF_FFFF, r, z, l, bo);
      n_checks++;
      if (r !== 32'h0 || z !== 1'b1) begin
         n_fail++;
         $display("FAIL slt_pos_ge: got res=%h zero=%b, want 00000000 1", r, z);
      end
      do_op(3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, r, z, l, bo);
      n_checks++;
      if (r !== 32'h0F0F_F0F0 || z !== 1'b0) begin
         n_fail++;
         $display("FAIL xor: got res=%h zero=%b, want 0f0ff0f0 0", r, z);
      end
   endtask

   task automatic test_shift();
      logic [31:0] r; logic z; int l; bit bo;
      do_op(3'd6, 32'h1, 32'h0000_003F, r, z, l, bo);
      n_checks++;
      if (r !== 32'h8000_0000 || l != 32) begin
         n_fail++;
         $display("FAIL sll_max: got res=%h lat=%0d, want 80000000 32", r, l);
      end
      n_checks++;
      if (bo !== 1'b1) begin
         n_fail++;
         $display("FAIL sll_busy: got in_ready/busy deviation=%b, want 1 (in_ready=0 busy=1 held)", bo);
      end
      do_op(3'd7, 32'h8000_0000, 32'hFFFF_FFE0, r, z, l, bo);
      n_checks++;
      if (r !== 32'h8000_0000 || l != 1) begin
         n_fail++;
         $display("FAIL srl_zero: got res=%h lat=%0d, want 80000000 1", r, l);
      end
      do_op(3'd7, 32'hDEAD_BEEF, 32'h0000_0004, r, z, l, bo);
      n_checks++;
      if (r !== 32'h0DEA_DBEE || l != 5) begin
         n_fail++;
         $display("FAIL srl_4: got res=%h lat=%0d, want 0deadbee 5", r, l);
      end
   endtask

   task automatic test_back_pressure();
      logic [31:0] r; logic z; int l; bit bo;
      @(negedge clk);
      ALUControl = 3'd2;
      SrcA       = 32'hF0F0_1234;
      SrcB       = 32'h0FF0_FFFF;
      in_valid   = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         in_valid   = 1'b1;
         ALUControl = 3'd0;
         SrcA       = $urandom;
         SrcB       = $urandom;
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || ALUResult !== 32'h00F0_1234 ||
             Zero !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got out_valid=%b in_ready=%b res=%h zero=%b, want 1 0 00f01234 0",
                     i, out_valid, in_ready, ALUResult, Zero);
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUResult !== 32'h00F0_1234) begin
         n_fail++;
         $display("FAIL stall_release: got out_valid=%b in_ready=%b res=%h, want 0 1 00f01234",
                  out_valid, in_ready, ALUResult);
      end
      $display("op=2 a=f0f01234 b=0ff0ffff res=%h held 10 cycles", ALUResult);
      do_op(3'd3, 32'h1200_0000, 32'h0000_0034, r, z, l, bo);
      n_checks++;
      if (r !== 32'h1200_0034 || z !== 1'b0 || l != 1) begin
         n_fail++;
         $display("FAIL or: got res=%h zero=%b lat=%0d, want 12000034 0 1", r, z, l);
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [31:0] r; logic z; int l; bit bo;
      @(negedge clk);
      ALUControl = 3'd7;
      SrcA       = 32'hFFFF_0000;
      SrcB       = 32'd20;
      in_valid   = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      n_checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_reset_shift: got busy=%b out_valid=%b, want 1 0", busy, out_valid);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || ALUResult !== 32'h0 ||
          Zero !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got in_ready=%b out_valid=%b res=%h zero=%b busy=%b, want 1 0 00000000 1 0",
                  in_ready, out_valid, ALUResult, Zero, busy);
      end
      $display("srl by 20 aborted by reset mid-shift");
      @(negedge clk);
      rst = 1'b0;
      do_op(3'd0, 32'd3, 32'd4, r, z, l, bo);
      n_checks++;
      if (r !== 32'd7 || l != 1) begin
         n_fail++;
         $display("FAIL post_reset_add: got res=%h lat=%0d, want 00000007 1", r, l);
      end
   endtask

   task automatic test_random_stream();
      logic [31:0] exp_q[$];
      logic [31:0] expv;
      int          sent;
      int          got;
      int          cyc;
      sent = 0;
      got  = 0;
      cyc  = 0;
      while (got < 1000 && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         in_valid   = (sent < 1000) && ($urandom_range(0, 3) != 0);
         ALUControl = 3'($urandom_range(0, 7));
         SrcA       = $urandom;
         SrcB       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
         out_ready  = ($urandom_range(0, 2) != 0);
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_alu(ALUControl, SrcA, SrcB));
            sent++;
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rand_extra: got res=%h with no request outstanding, want none", ALUResult);
            end else begin
               expv = exp_q.pop_front();
               if (ALUResult !== expv || Zero !== (expv == 32'h0)) begin
                  n_fail++;
                  $display("FAIL rand_result[%0d]: got res=%h zero=%b, want %h %b",
                           got, ALUResult, Zero, expv, (expv == 32'h0));
               end else begin
                  $display("rand #%0d res=%h zero=%b", got, ALUResult, Zero);
               end
            end
            got++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_checks++;
      if (got != 1000 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rand_count: got %0d results with %0d pending, want 1000 and 0",
                  got, exp_q.size());
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      ALUControl = 3'd0;
      SrcA       = 32'h0;
      SrcB       = 32'h0;
      test_reset();
      test_arith();
      test_slt_xor();
      test_shift();
      test_back_pressure();
      test_reset_mid_shift();
      test_random_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
